traffic_phase_scheduler: RTL and testbench

Request-driven phase scheduler for a four-way intersection. It grants green to one approach at a time (North, East, South, West) in round-robin order among the approaches with pending vehicle requests. Each green is followed by a timed yellow and an all-red clearance. It drives the same 2-bit per-approach light buses as the fixed-cycle traffic controller and replaces it where detector loops are fitted.

---
 rtl/traffic_phase_scheduler_if.sv | 21 ++
 rtl/traffic_phase_scheduler.sv | 88 ++++++++
 tb/tb_traffic_phase_scheduler.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/traffic_phase_scheduler_if.sv
// traffic_phase_scheduler_if: request/preempt inputs and light/status outputs of the phase scheduler
interface traffic_phase_scheduler_if;
   logic [3:0] req;
   logic       emerg_valid;
   logic [1:0] emerg_dir;
   logic [1:0] North_light;
   logic [1:0] East_light;
   logic [1:0] South_light;
   logic [1:0] West_light;
   logic [1:0] phase;
   logic [1:0] active_dir;
   logic       preempt_active;
   modport master (
      output req, emerg_valid, emerg_dir,
      input  North_light, East_light, South_light, West_light, phase, active_dir, preempt_active
   );
   modport slave (
      input  req, emerg_valid, emerg_dir,
      output North_light, East_light, South_light, West_light, phase, active_dir, preempt_active
   );
endinterface

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: round-robin request-driven green/yellow/all-red scheduler; EMERG_PREEMPT_EN adds emergency preemption
module traffic_phase_scheduler #(
   parameter int GREEN_MIN = 4,
   parameter int GREEN_MAX = 10,
   parameter int YELLOW_T  = 2,
   parameter int ALLRED_T  = 2,
   parameter int TIMER_W   = 8
) (
   input logic clk,
   input logic rst,
   traffic_phase_scheduler_if.slave bus
);
   localparam logic [1:0] S_AR = 2'b00;
   localparam logic [1:0] S_GR = 2'b01;
   localparam logic [1:0] S_YE = 2'b10;
   localparam logic [TIMER_W-1:0] L_AR   = TIMER_W'(ALLRED_T - 1);
   localparam logic [TIMER_W-1:0] L_GMIN = TIMER_W'(GREEN_MIN - 1);
   localparam logic [TIMER_W-1:0] L_GMAX = TIMER_W'(GREEN_MAX - 1);
   localparam logic [TIMER_W-1:0] L_YE   = TIMER_W'(YELLOW_T - 1);

   logic [1:0]         r_state, r_dir, w_state, w_next_dir, w_grant, w_edir, w_on;
   logic [TIMER_W-1:0] r_timer, w_lim;
   logic               r_preempt, w_emerg;
   logic [3:0]         w_others;

`ifdef EMERG_PREEMPT_EN
   assign w_emerg = bus.emerg_valid;
   assign w_edir  = bus.emerg_dir;
`else
   logic w_unused;
   assign w_unused = ^{bus.emerg_valid, bus.emerg_dir};
   assign w_emerg  = 1'b0;
   assign w_edir   = 2'd0;
`endif

   assign w_others = bus.req & ~(4'b0001 << r_dir);
   assign w_grant  = w_emerg ? w_edir : w_next_dir;
   assign w_lim    = (r_state == S_AR) ? L_AR : (r_state == S_GR) ? L_GMAX : L_YE;

   // round-robin search: nearest requesting direction after r_dir, r_dir itself last
   always_comb begin
      w_next_dir = r_dir;
      for (int i = 4; i >= 1; i--)
         if (bus.req[r_dir + 2'(i)]) w_next_dir = r_dir + 2'(i);
   end

   // state register with phase timer, granted direction and preempt flag
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_AR;
         r_dir     <= 2'd3;
         r_timer   <= '0;
         r_preempt <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_timer   <= (w_state != r_state) ? '0 : (r_timer >= w_lim) ? r_timer : r_timer + 1'b1;
         r_dir     <= (r_state == S_AR && w_state == S_GR) ? w_grant : r_dir;
         r_preempt <= w_emerg;
      end
   end

   // next-state: timed clearance, gap-out/max-out from green, preemption overrides green timing
   always_comb begin
      w_state = r_state;
      case (r_state)
         S_AR: if (r_timer >= L_AR && (w_emerg || bus.req != 4'd0)) w_state = S_GR;
         S_GR: if (w_emerg) begin
                  if (w_edir != r_dir) w_state = S_YE;
               end else if (w_others != 4'd0 &&
                            ((r_timer >= L_GMIN && !bus.req[r_dir]) || r_timer >= L_GMAX))
                  w_state = S_YE;
         S_YE: if (r_timer >= L_YE) w_state = S_AR;
         default: w_state = S_AR;
      endcase
   end

   // output decode from registered phase and direction only
   always_comb begin
      w_on               = (r_state == S_GR) ? 2'b10 : (r_state == S_YE) ? 2'b01 : 2'b00;
      bus.North_light    = (r_dir == 2'd0) ? w_on : 2'b00;
      bus.East_light     = (r_dir == 2'd1) ? w_on : 2'b00;
      bus.South_light    = (r_dir == 2'd2) ? w_on : 2'b00;
      bus.West_light     = (r_dir == 2'd3) ? w_on : 2'b00;
      bus.phase          = r_state;
      bus.active_dir     = r_dir;
      bus.preempt_active = r_preempt;
   end
endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb_traffic_phase_scheduler: table-driven directed vectors plus hand-written max-out and mid-phase reset sequences
module tb_traffic_phase_scheduler;
   localparam logic [1:0] AR = 2'b00, GR = 2'b01, YE = 2'b10;
   localparam logic [7:0] N_G = 8'h02, N_Y = 8'h01, E_G = 8'h08, E_Y = 8'h04;
   localparam logic [7:0] S_G = 8'h20, W_G = 8'h80, W_Y = 8'h40;

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic       ev;
      logic [1:0] ed;
      logic [7:0] lt;
      logic [1:0] ph;
      logic [1:0] dir;
      logic       pre;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;
   vec_t vq[$];

   traffic_phase_scheduler_if ifc ();
   traffic_phase_scheduler dut (.clk(clk), .rst(rst), .bus(ifc.slave));

   always #5 clk = ~clk;

   function automatic logic [7:0] lights();
      return {ifc.West_light, ifc.South_light, ifc.East_light, ifc.North_light};
   endfunction

   task automatic adde(input logic r, input logic [3:0] q, input logic ev, input logic [1:0] ed,
                       input logic [7:0] lt, input logic [1:0] ph, input logic [1:0] dir, input logic pre);
      vec_t v;
      v.rst = r; v.req = q; v.ev = ev; v.ed = ed; v.lt = lt; v.ph = ph; v.dir = dir; v.pre = pre;
      vq.push_back(v);
   endtask

   task automatic add(input logic r, input logic [3:0] q, input logic [7:0] lt,
                      input logic [1:0] ph, input logic [1:0] dir);
      adde(r, q, 1'b0, 2'd0, lt, ph, dir, 1'b0);
   endtask

   task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got lights=%h phase=%0d dir=%0d pre=%0d, expected lights=%h phase=%0d dir=%0d pre=%0d",
                  name, act[12:5], act[4:3], act[2:1], act[0], exp[12:5], exp[4:3], exp[2:1], exp[0]);
      end
   endtask

   task automatic check_safe(input int k);
      logic [7:0] l;
      l = lights();
      n_tests++;
      if ($countones({|l[7:6], |l[5:4], |l[3:2], |l[1:0]}) > 1 ||
          l[7:6] == 2'b11 || l[5:4] == 2'b11 || l[3:2] == 2'b11 || l[1:0] == 2'b11) begin
         n_fail++;
         $display("FAIL safety vec %0d: lights=%h, expected at most one non-red and no 11", k, l);
      end
   endtask

   initial begin
      int g;
      ifc.req = 4'd0; ifc.emerg_valid = 1'b0; ifc.emerg_dir = 2'd0;
      // reset and idle
      add(1, 0, 0, AR, 3); add(1, 0, 0, AR, 3);
      for (int i = 0; i < 20; i++) add(0, 0, 0, AR, 3);
      // single request rests in green
      add(1, 0, 0, AR, 3);
      add(0, 4'b0001, 0, AR, 3);
      for (int i = 0; i < 16; i++) add(0, 4'b0001, N_G, GR, 0);
      // gap-out after N drops
      add(1, 0, 0, AR, 3);
      add(0, 4'b0001, 0, AR, 3);
      add(0, 4'b0001, N_G, GR, 0);
      for (int i = 0; i < 3; i++) add(0, 4'b0010, N_G, GR, 0);
      add(0, 4'b0010, N_Y, YE, 0); add(0, 4'b0010, N_Y, YE, 0);
      add(0, 4'b0010, 0, AR, 0);   add(0, 4'b0010, 0, AR, 0);
      add(0, 4'b0010, E_G, GR, 1);
      // max-out N <-> E
      add(1, 0, 0, AR, 3);
      add(0, 4'b0011, 0, AR, 3);
      for (int i = 0; i < 10; i++) add(0, 4'b0011, N_G, GR, 0);
      add(0, 4'b0011, N_Y, YE, 0); add(0, 4'b0011, N_Y, YE, 0);
      add(0, 4'b0011, 0, AR, 0);   add(0, 4'b0011, 0, AR, 0);
      for (int i = 0; i < 10; i++) add(0, 4'b0011, E_G, GR, 1);
      add(0, 4'b0011, E_Y, YE, 1); add(0, 4'b0011, E_Y, YE, 1);
      add(0, 4'b0011, 0, AR, 1);   add(0, 4'b0011, 0, AR, 1);
      add(0, 4'b0011, N_G, GR, 0);
      // wrap N <-> W, then reset mid-green
      add(1, 0, 0, AR, 3);
      add(0, 4'b1001, 0, AR, 3);
      for (int i = 0; i < 10; i++) add(0, 4'b1001, N_G, GR, 0);
      add(0, 4'b1001, N_Y, YE, 0); add(0, 4'b1001, N_Y, YE, 0);
      add(0, 4'b1001, 0, AR, 0);   add(0, 4'b1001, 0, AR, 0);
      for (int i = 0; i < 10; i++) add(0, 4'b1001, W_G, GR, 3);
      add(0, 4'b1001, W_Y, YE, 3); add(0, 4'b1001, W_Y, YE, 3);
      add(0, 4'b1001, 0, AR, 3);   add(0, 4'b1001, 0, AR, 3);
      add(0, 4'b1001, N_G, GR, 0);
      add(1, 4'b1001, 0, AR, 3);
      // request dropped before grant is not served; then 1-edge latency once expired
      add(1, 0, 0, AR, 3);
      add(0, 4'b0100, 0, AR, 3);
      add(0, 4'b0000, 0, AR, 3);
      add(0, 4'b0000, 0, AR, 3);
      add(0, 4'b0100, S_G, GR, 2);
      // emergency preemption of E green at timer=1 towards S
      add(1, 0, 0, AR, 3);
      add(0, 4'b0010, 0, AR, 3);
      add(0, 4'b0010, E_G, GR, 1);
      add(0, 4'b0010, E_G, GR, 1);
`ifdef EMERG_PREEMPT_EN
      adde(0, 4'b0010, 1, 2, E_Y, YE, 1, 1); adde(0, 4'b0010, 1, 2, E_Y, YE, 1, 1);
      adde(0, 4'b0010, 1, 2, 0, AR, 1, 1);   adde(0, 4'b0010, 1, 2, 0, AR, 1, 1);
      for (int i = 0; i < 13; i++) adde(0, 4'b0010, 1, 2, S_G, GR, 2, 1);
      adde(0, 4'b0100, 0, 2, S_G, GR, 2, 0);
`else
      for (int i = 0; i < 17; i++) adde(0, 4'b0010, 1, 2, E_G, GR, 1, 0);
      adde(0, 4'b0100, 0, 2, E_Y, YE, 1, 0);
`endif

      foreach (vq[k]) begin
         @(negedge clk);
         rst = vq[k].rst; ifc.req = vq[k].req; ifc.emerg_valid = vq[k].ev; ifc.emerg_dir = vq[k].ed;
         @(posedge clk); #1;
         check($sformatf("vec %0d", k),
               {lights(), ifc.phase, ifc.active_dir, ifc.preempt_active},
               {vq[k].lt, vq[k].ph, vq[k].dir, vq[k].pre});
         check_safe(k);
      end

      // hand-written: measure max-out green length with bounded waits, then reset mid-yellow
      @(negedge clk); rst = 1'b1; ifc.req = 4'b0011; ifc.emerg_valid = 1'b0;
      @(negedge clk); rst = 1'b0;
      g = 0;
      for (int i = 0; i < 10 && ifc.phase != GR; i++) begin @(posedge clk); #1; end
      while (ifc.phase == GR && g < 50) begin g++; @(posedge clk); #1; end
      n_tests++;
      if (g != 10) begin n_fail++; $display("FAIL maxout_len: got %0d green cycles, expected 10", g); end
      check("post_maxout_yellow", {lights(), ifc.phase, ifc.active_dir, ifc.preempt_active}, {N_Y, YE, 2'd0, 1'b0});
      rst = 1'b1;
      @(posedge clk); #1;
      check("reset_mid_yellow", {lights(), ifc.phase, ifc.active_dir, ifc.preempt_active}, {8'h00, AR, 2'd3, 1'b0});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
